// File: rtl/gate_resp_checker_if.sv
// Sample/result bundle between a gate-under-test harness and gate_resp_checker.
interface gate_resp_checker_if #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned TT_W = 1 << N_IN;

  logic              start;
  logic [TT_W-1:0]   exp_tt;
  logic              smp_valid;
  logic [N_IN-1:0]   smp_in;
  logic              smp_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_cnt;
  logic              first_err_vld;
  logic [N_IN-1:0]   first_err_idx;
  logic [TT_W-1:0]   cap_tt;
  logic [TT_W-1:0]   seen;

  modport master (
    output start, exp_tt, smp_valid, smp_in, smp_out,
    input  busy, done, pass, err_cnt, first_err_vld, first_err_idx, cap_tt, seen
  );

  modport slave (
    input  start, exp_tt, smp_valid, smp_in, smp_out,
    output busy, done, pass, err_cnt, first_err_vld, first_err_idx, cap_tt, seen
  );
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for a small combinational gate: captures its truth table,
// compares against an expected table and reports errors and input coverage.
module gate_resp_checker #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_resp_checker_if.slave  bus
);
  localparam int unsigned TT_W = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state, state_nxt;
  logic [TT_W-1:0]   exp_reg, exp_nxt;
  logic [TT_W-1:0]   cap_tt, cap_nxt;
  logic [TT_W-1:0]   seen, seen_nxt;
  logic [CNT_W-1:0]  err_cnt, err_nxt;
  logic              fvld, fvld_nxt;
  logic [N_IN-1:0]   fidx, fidx_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              pass, pass_nxt;
  logic              mismatch;

  // State and result registers; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      exp_reg <= '0;
      cap_tt  <= '0;
      seen    <= '0;
      err_cnt <= '0;
      fvld    <= 1'b0;
      fidx    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_nxt;
      exp_reg <= exp_nxt;
      cap_tt  <= cap_nxt;
      seen    <= seen_nxt;
      err_cnt <= err_nxt;
      fvld    <= fvld_nxt;
      fidx    <= fidx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      pass    <= pass_nxt;
    end
  end

  assign mismatch = (bus.smp_out != exp_reg[bus.smp_in]);

  // Next-state and result update; samples only count while collecting.
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_reg;
    cap_nxt   = cap_tt;
    seen_nxt  = seen;
    err_nxt   = err_cnt;
    fvld_nxt  = fvld;
    fidx_nxt  = fidx;
    pass_nxt  = pass;

    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = COLLECT;
          exp_nxt   = bus.exp_tt;
          cap_nxt   = '0;
          seen_nxt  = '0;
          err_nxt   = '0;
          fvld_nxt  = 1'b0;
          fidx_nxt  = '0;
          pass_nxt  = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.smp_valid) begin
          cap_nxt[bus.smp_in]  = bus.smp_out;
          seen_nxt[bus.smp_in] = 1'b1;
          if (mismatch) begin
            if (err_cnt != {CNT_W{1'b1}}) err_nxt = err_cnt + CNT_W'(1);
            if (!fvld) begin
              fvld_nxt = 1'b1;
              fidx_nxt = bus.smp_in;
            end
          end
          // Completing sample is included in the verdict.
          if (&seen_nxt) begin
            state_nxt = DONE;
            pass_nxt  = (err_nxt == '0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == COLLECT);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_vld = fvld;
  assign bus.first_err_idx = fidx;
  assign bus.cap_tt        = cap_tt;
  assign bus.seen          = seen;
endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench: two checkers (8-bit and 2-bit error counters) driven in lockstep.
module tb_gate_resp_checker;
  localparam int unsigned N_IN = 2;
  localparam int unsigned TT_W = 4;

  typedef struct {
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] e8;
    logic [1:0] e2;
    logic       fv;
    logic [1:0] fi;
    logic [3:0] cap;
    logic [3:0] seen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_resp_checker_if #(.N_IN(N_IN), .CNT_W(8)) bus8 ();
  gate_resp_checker_if #(.N_IN(N_IN), .CNT_W(2)) bus2 ();

  gate_resp_checker #(.N_IN(N_IN), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  gate_resp_checker #(.N_IN(N_IN), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int failures = 0;

  exp_t  sb_q[$];
  string tag_q[$];

  // Reference model state: 0 idle, 1 collecting, 2 done.
  int         m_state;
  logic [3:0] m_exp, m_cap, m_seen;
  int         m_e8, m_e2;
  logic       m_fv, m_pass;
  logic [1:0] m_fi;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_exp = 4'h0; m_cap = 4'h0; m_seen = 4'h0;
    m_e8 = 0; m_e2 = 0; m_fv = 1'b0; m_fi = 2'd0; m_pass = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic [3:0] et, input logic v,
                            input logic [1:0] si, input logic so);
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_exp = et; m_cap = 4'h0; m_seen = 4'h0;
        m_e8 = 0; m_e2 = 0; m_fv = 1'b0; m_fi = 2'd0; m_pass = 1'b0;
      end
    end else if (v) begin
      m_cap[si] = so;
      m_seen[si] = 1'b1;
      if (so != m_exp[si]) begin
        if (m_e8 < 255) m_e8++;
        if (m_e2 < 3) m_e2++;
        if (!m_fv) begin m_fv = 1'b1; m_fi = si; end
      end
      if (m_seen == 4'hF) begin
        m_state = 2;
        m_pass = (m_e8 == 0);
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.busy = (m_state == 1); e.done = (m_state == 2); e.pass = m_pass;
    e.e8 = 8'(m_e8); e.e2 = 2'(m_e2); e.fv = m_fv; e.fi = m_fi;
    e.cap = m_cap; e.seen = m_seen;
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check_eq({tag, ".busy"},  32'(bus8.busy), 32'(e.busy));
    check_eq({tag, ".done"},  32'(bus8.done), 32'(e.done));
    check_eq({tag, ".pass"},  32'(bus8.pass), 32'(e.pass));
    check_eq({tag, ".err8"},  32'(bus8.err_cnt), 32'(e.e8));
    check_eq({tag, ".fvld"},  32'(bus8.first_err_vld), 32'(e.fv));
    check_eq({tag, ".fidx"},  32'(bus8.first_err_idx), 32'(e.fi));
    check_eq({tag, ".cap"},   32'(bus8.cap_tt), 32'(e.cap));
    check_eq({tag, ".seen"},  32'(bus8.seen), 32'(e.seen));
    check_eq({tag, ".busy2"}, 32'(bus2.busy), 32'(e.busy));
    check_eq({tag, ".done2"}, 32'(bus2.done), 32'(e.done));
    check_eq({tag, ".pass2"}, 32'(bus2.pass), 32'(e.pass));
    check_eq({tag, ".err2"},  32'(bus2.err_cnt), 32'(e.e2));
    check_eq({tag, ".fidx2"}, 32'(bus2.first_err_idx), 32'(e.fi));
    check_eq({tag, ".cap2"},  32'(bus2.cap_tt), 32'(e.cap));
    check_eq({tag, ".seen2"}, 32'(bus2.seen), 32'(e.seen));
  endtask

  task automatic drive(input logic st, input logic [3:0] et, input logic v,
                       input logic [1:0] si, input logic so);
    bus8.start = st; bus8.exp_tt = et; bus8.smp_valid = v; bus8.smp_in = si; bus8.smp_out = so;
    bus2.start = st; bus2.exp_tt = et; bus2.smp_valid = v; bus2.smp_in = si; bus2.smp_out = so;
  endtask

  // One clock of stimulus: push the model's prediction, then pop and compare after the edge.
  task automatic step(input string tag, input logic st, input logic [3:0] et, input logic v,
                      input logic [1:0] si, input logic so);
    exp_t  e;
    string t;
    drive(st, et, v, si, so);
    model_step(st, et, v, si, so);
    sb_q.push_back(snap());
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    compare_all(t, e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    drive(1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset", snap());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // AND2 reference, all vectors in order
    step("t1_start", 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    step("t1_s0", 1'b0, 4'h0, 1'b1, 2'd0, 1'b0);
    step("t1_s1", 1'b0, 4'h0, 1'b1, 2'd1, 1'b0);
    step("t1_s2", 1'b0, 4'h0, 1'b1, 2'd2, 1'b0);
    step("t1_s3", 1'b0, 4'h0, 1'b1, 2'd3, 1'b1);
    idle("t1_hold", 2);

    // Faulty gate: two mismatches, first on vector 1
    step("t2_start", 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    step("t2_s0", 1'b0, 4'h0, 1'b1, 2'd0, 1'b0);
    step("t2_s1", 1'b0, 4'h0, 1'b1, 2'd1, 1'b1);
    step("t2_s2", 1'b0, 4'h0, 1'b1, 2'd2, 1'b0);
    step("t2_s3", 1'b0, 4'h0, 1'b1, 2'd3, 1'b0);
    idle("t2_hold", 1);

    // Repeats, gaps and a start pulse mid-run
    step("t3_start", 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    step("t3_s0a", 1'b0, 4'h0, 1'b1, 2'd0, 1'b0);
    idle("t3_gap", 3);
    step("t3_s0b", 1'b0, 4'h0, 1'b1, 2'd0, 1'b1);
    step("t3_s1", 1'b0, 4'h0, 1'b1, 2'd1, 1'b0);
    step("t3_s2", 1'b0, 4'h0, 1'b1, 2'd2, 1'b0);
    step("t3_midstart", 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    step("t3_s3", 1'b0, 4'h0, 1'b1, 2'd3, 1'b1);
    idle("t3_hold", 1);

    // Saturation of the narrow counter
    step("t4_start", 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) step("t4_bad0", 1'b0, 4'h0, 1'b1, 2'd0, 1'b1);
    step("t4_s1", 1'b0, 4'h0, 1'b1, 2'd1, 1'b0);
    step("t4_s2", 1'b0, 4'h0, 1'b1, 2'd2, 1'b0);
    step("t4_s3", 1'b0, 4'h0, 1'b1, 2'd3, 1'b1);

    // Samples ignored in DONE; restart with a simultaneous sample
    step("t5_done_smp", 1'b0, 4'h0, 1'b1, 2'd0, 1'b0);
    step("t5_restart", 1'b1, 4'b1110, 1'b1, 2'd2, 1'b0);
    step("t5_s0", 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    step("t5_s1", 1'b0, 4'b0001, 1'b1, 2'd1, 1'b1);
    step("t5_s2", 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1);
    step("t5_s3", 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1);

    // Asynchronous reset mid-run
    step("t6_start", 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0);
    step("t6_s0", 1'b0, 4'h0, 1'b1, 2'd0, 1'b1);
    step("t6_s1", 1'b0, 4'h0, 1'b1, 2'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("t6_async_rst", snap());
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_ign0", 1'b0, 4'h0, 1'b1, 2'd3, 1'b1);
    step("t6_ign1", 1'b0, 4'h0, 1'b1, 2'd1, 1'b0);

    // Random run on a random expected table
    begin
      logic [3:0] et;
      logic [3:0] gate;
      et = 4'($urandom_range(0, 15));
      gate = et ^ 4'($urandom_range(0, 15));
      step("rnd_start", 1'b1, et, 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 40 && m_state == 1; i++) begin
        logic [1:0] si;
        si = 2'($urandom_range(0, 3));
        step("rnd_smp", 1'b0, 4'h0, 1'($urandom_range(0, 1)), si, gate[si]);
      end
      for (int k = 0; k < 4 && m_state == 1; k++) begin
        logic [1:0] sk;
        sk = 2'(k);
        step("rnd_fill", 1'b0, 4'h0, 1'b1, sk, gate[sk]);
      end
      idle("rnd_hold", 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
